// File: rtl/shift_pkg.sv
// Shared constants and state encoding for the multi-mode shift register.
package shift_pkg;

  localparam logic [1:0] MODE_LOGIC  = 2'd0;
  localparam logic [1:0] MODE_ARITH  = 2'd1;
  localparam logic [1:0] MODE_ROT    = 2'd2;
  localparam logic [1:0] MODE_SERIAL = 2'd3;

  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shift: picks the incoming bit by mode and
// direction, then shifts the word by one place.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] word,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             fill,
  output logic [WIDTH-1:0] next_word
);

  logic in_bit;

  always_comb begin
    in_bit = 1'b0;
    if (dir == DIR_RIGHT) begin
      unique case (mode)
        MODE_LOGIC:  in_bit = 1'b0;
        MODE_ARITH:  in_bit = word[WIDTH-1];
        MODE_ROT:    in_bit = word[0];
        MODE_SERIAL: in_bit = fill;
      endcase
    end else begin
      // Arithmetic left is identical to logical left.
      unique case (mode)
        MODE_LOGIC:  in_bit = 1'b0;
        MODE_ARITH:  in_bit = 1'b0;
        MODE_ROT:    in_bit = word[WIDTH-1];
        MODE_SERIAL: in_bit = fill;
      endcase
    end
  end

  always_comb begin
    next_word = word;
    if (dir == DIR_RIGHT) begin
      next_word = {in_bit, word[WIDTH-1:1]};
    end else begin
      next_word = {word[WIDTH-2:0], in_bit};
    end
  end

endmodule

// File: rtl/multi_mode_shift_register.sv
// Multi-cycle shift/rotate unit: loads a word, shifts one place per clock for
// a clamped amount, then pulses done with the result held on dataOut.
module multi_mode_shift_register
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic             serialIn,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
);

  state_t           state_q;
  logic             dir_q;
  logic [1:0]       mode_q;
  logic             fill_q;
  logic [AMT_W-1:0] count_q;
  logic [AMT_W-1:0] amt_clamped;
  logic [WIDTH-1:0] step_word;

  assign amt_clamped = (amount > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amount;
  assign busy        = (state_q == SHIFT);

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .word     (dataOut),
    .dir      (dir_q),
    .mode     (mode_q),
    .fill     (fill_q),
    .next_word(step_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dataOut <= '0;
      dir_q   <= 1'b0;
      mode_q  <= MODE_LOGIC;
      fill_q  <= 1'b0;
      count_q <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            dataOut <= dataIn;
            dir_q   <= dir;
            mode_q  <= mode;
            fill_q  <= serialIn;
            count_q <= amt_clamped;
            // A zero-length request completes on the accepting edge.
            if (amt_clamped == '0) begin
              done <= 1'b1;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          dataOut <= step_word;
          count_q <= count_q - AMT_W'(1);
          if (count_q == AMT_W'(1)) begin
            state_q <= IDLE;
            done    <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_mode_shift_register.sv
// Directed table-driven bench for multi_mode_shift_register (WIDTH=8).
module tb_multi_mode_shift_register;

  localparam int WIDTH = 8;
  localparam int AMT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             dir;
  logic [1:0]       mode;
  logic [AMT_W-1:0] amount;
  logic             serialIn;
  logic [WIDTH-1:0] dataIn;
  logic [WIDTH-1:0] dataOut;
  logic             busy;
  logic             done;

  int n_total = 0;
  int n_pass  = 0;

  multi_mode_shift_register #(
    .WIDTH(WIDTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .dir     (dir),
    .mode    (mode),
    .amount  (amount),
    .serialIn(serialIn),
    .dataIn  (dataIn),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic       dir;
    logic [1:0] mode;
    logic [3:0] amt;
    logic       sin;
    logic [7:0] exp_out;
    int         exp_lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Issue one start and watch until done, bounded to 20 cycles.
  task automatic run_op(input logic [7:0] din, input logic d, input logic [1:0] m,
                        input logic [3:0] amt, input logic sin,
                        output logic [7:0] res, output int lat, output int busy_n,
                        output logic busy_at_done, output logic done_after);
    @(negedge clk);
    start = 1'b1; dataIn = din; dir = d; mode = m; amount = amt; serialIn = sin;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    busy_n = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      if (busy) busy_n++;
      @(negedge clk);
    end
    res = dataOut;
    busy_at_done = busy;
    @(negedge clk);
    done_after = done;
  endtask

  initial begin
    logic [7:0] res;
    int         lat;
    int         bn;
    logic       bd;
    logic       da;
    int         seen;

    vecs[0]  = '{8'h96, 1'b1, 2'd0, 4'd3,  1'b0, 8'h12, 3};
    vecs[1]  = '{8'h96, 1'b1, 2'd1, 4'd2,  1'b0, 8'hE5, 2};
    vecs[2]  = '{8'h96, 1'b0, 2'd1, 4'd2,  1'b0, 8'h58, 2};
    vecs[3]  = '{8'h81, 1'b0, 2'd2, 4'd1,  1'b0, 8'h03, 1};
    vecs[4]  = '{8'h81, 1'b0, 2'd2, 4'd8,  1'b0, 8'h81, 8};
    vecs[5]  = '{8'h81, 1'b0, 2'd2, 4'd15, 1'b0, 8'h81, 8};
    vecs[6]  = '{8'h00, 1'b1, 2'd3, 4'd4,  1'b1, 8'hF0, 4};
    vecs[7]  = '{8'h96, 1'b1, 2'd0, 4'd8,  1'b0, 8'h00, 8};
    vecs[8]  = '{8'h96, 1'b1, 2'd1, 4'd8,  1'b0, 8'hFF, 8};
    vecs[9]  = '{8'h5A, 1'b0, 2'd3, 4'd8,  1'b1, 8'hFF, 8};
    vecs[10] = '{8'h5A, 1'b0, 2'd3, 4'd8,  1'b0, 8'h00, 8};
    vecs[11] = '{8'hA5, 1'b0, 2'd0, 4'd0,  1'b0, 8'hA5, 0};
    vecs[12] = '{8'h01, 1'b1, 2'd2, 4'd1,  1'b0, 8'h80, 1};
    vecs[13] = '{8'h80, 1'b0, 2'd0, 4'd1,  1'b0, 8'h00, 1};

    reset = 1'b1; start = 1'b0; dir = 1'b0; mode = 2'd0; amount = '0;
    serialIn = 1'b0; dataIn = 8'h00;
    #1;
    chk("reset dataOut", 32'(dataOut), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].din, vecs[i].dir, vecs[i].mode, vecs[i].amt, vecs[i].sin,
             res, lat, bn, bd, da);
      chk($sformatf("vec%0d dataOut", i), 32'(res), 32'(vecs[i].exp_out));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d busy cycles", i), 32'(bn), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d busy at done", i), 32'(bd), 32'h0);
      chk($sformatf("vec%0d done one cycle", i), 32'(da), 32'h0);
    end

    // Latched controls: changing inputs mid-operation must not matter.
    @(negedge clk);
    start = 1'b1; dataIn = 8'h00; dir = 1'b1; mode = 2'd3; amount = 4'd4; serialIn = 1'b1;
    @(negedge clk);
    start = 1'b0; serialIn = 1'b0; dir = 1'b0; mode = 2'd0; dataIn = 8'h3C; amount = 4'd1;
    seen = -1;
    for (int c = 0; c < 20; c++) begin
      if (done) begin seen = c; break; end
      @(negedge clk);
    end
    chk("latched serialIn latency", 32'(seen), 32'd4);
    chk("latched serialIn result", 32'(dataOut), 32'hF0);

    // Start held high: ignored while busy, accepted again in the done cycle.
    @(negedge clk);
    start = 1'b1; dataIn = 8'h96; dir = 1'b1; mode = 2'd0; amount = 4'd2;
    @(negedge clk);
    chk("b2b n1 busy", 32'(busy), 32'h1);
    chk("b2b n1 dataOut", 32'(dataOut), 32'h96);
    dataIn = 8'hFF; amount = 4'd7;
    @(negedge clk);
    chk("b2b n2 done", 32'(done), 32'h0);
    chk("b2b n2 dataOut", 32'(dataOut), 32'h4B);
    @(negedge clk);
    chk("b2b n3 done", 32'(done), 32'h1);
    chk("b2b n3 busy", 32'(busy), 32'h0);
    chk("b2b n3 dataOut", 32'(dataOut), 32'h25);
    dataIn = 8'h0F; dir = 1'b0; mode = 2'd2; amount = 4'd1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b n4 dataOut", 32'(dataOut), 32'h0F);
    chk("b2b n4 busy", 32'(busy), 32'h1);
    chk("b2b n4 done", 32'(done), 32'h0);
    @(negedge clk);
    chk("b2b n5 done", 32'(done), 32'h1);
    chk("b2b n5 dataOut", 32'(dataOut), 32'h1E);
    @(negedge clk);
    chk("b2b n6 done", 32'(done), 32'h0);

    // Asynchronous reset in the middle of an amount=5 operation.
    start = 1'b1; dataIn = 8'hFF; dir = 1'b1; mode = 2'd1; amount = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre-reset busy", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    chk("mid reset dataOut", 32'(dataOut), 32'h0);
    chk("mid reset busy", 32'(busy), 32'h0);
    chk("mid reset done", 32'(done), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("no done after reset", 32'(seen), 32'd0);
    run_op(8'h96, 1'b1, 2'd0, 4'd3, 1'b0, res, lat, bn, bd, da);
    chk("post-reset dataOut", 32'(res), 32'h12);
    chk("post-reset latency", 32'(lat), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
